// File: rtl/lsu_arb_pkg.sv
// Shared types, LSU address map and decode-error check for lsu_arbiter.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Address map, inclusive bounds, byte addresses.
  localparam logic [31:0] DMEM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DMEM_END    = 32'h0000_07FF;
  localparam logic [31:0] OUT_IO_BASE = 32'h0000_0800;
  localparam logic [31:0] OUT_IO_END  = 32'h0000_08AF;
  localparam logic [31:0] IN_IO_BASE  = 32'h0000_0900;
  localparam logic [31:0] IN_IO_END   = 32'h0000_091F;

  // Inclusive range test written as an offset compare so a zero base is not a trivial compare.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] last);
    return (addr - base) <= (last - base);
  endfunction

  // Decode error: address outside every region, or a store into the read-only input IO block.
  function automatic logic addr_err(input logic [31:0] addr, input logic we);
    logic ok;
    ok = in_range(addr, DMEM_BASE, DMEM_END)
      || in_range(addr, OUT_IO_BASE, OUT_IO_END)
      || (in_range(addr, IN_IO_BASE, IN_IO_END) && !we);
    return !ok;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (MODE=0) or round-robin from ptr (MODE=1),
// with an optional lock restricting eligibility to a single requester.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int MODE = 1,
  parameter int PW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          lock_valid,
  input  logic [PW-1:0] lock_idx,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [N-1:0]  eligible;
  logic [PW-1:0] idx;
  logic          found;

  // Pick the first eligible requester, scanning from index 0 or from ptr.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    eligible  = req;
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    if (lock_valid) begin
      for (int i = 0; i < N; i++) begin
        eligible[i] = req[i] && (PW'(i) == lock_idx);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (MODE == 0) idx = PW'(i);
      else           idx = PW'((int'(ptr) + i) % N);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one LSU port between N_REQ masters: arbitration, 3-cycle IDLE/ISSUE/RESP
// sequencing, decode-error suppression of stores, and per-master lock.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int ARB_MODE = 1,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [N_REQ-1:0]         req_we_i,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata_i,
  input  logic [N_REQ*3-1:0]       req_sel_i,
  input  logic [N_REQ-1:0]         req_lock_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REQ-1:0]         rsp_valid_o,
  output logic                     rsp_err_o,
  output logic [DATA_W-1:0]        rsp_rdata_o,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [DATA_W-1:0]        st_data_o,
  output logic                     st_en_o,
  output logic [2:0]               ld_st_sel_o,
  input  logic [DATA_W-1:0]        ld_data_i
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     lock_owner;
  logic              lock_valid;
  logic              lat_we;
  logic              lat_err;
  logic              st_en_q;

  logic [N_REQ-1:0]  grant;
  logic [PW-1:0]     grant_idx;
  logic [N_REQ-1:0]  owner_mask;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_sel;
  logic              sel_we;
  logic              sel_err;

  rr_arbiter #(
    .N    (N_REQ),
    .MODE (ARB_MODE),
    .PW   (PW)
  ) u_arb (
    .req        (req_valid_i),
    .ptr        (rr_ptr),
    .lock_valid (lock_valid),
    .lock_idx   (lock_owner),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Mux the winning master's request fields and decode its address.
  always_comb begin
    sel_addr  = req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata_i[int'(grant_idx)*DATA_W +: DATA_W];
    sel_sel   = req_sel_i[int'(grant_idx)*3 +: 3];
    sel_we    = req_we_i[grant_idx];
    sel_err   = addr_err(32'(sel_addr), sel_we);
    for (int i = 0; i < N_REQ; i++) begin
      owner_mask[i] = (PW'(i) == owner);
    end
  end

  // Grant is only offered in IDLE and never while reset is held.
  assign req_ready_o = (state == IDLE && !rst_i) ? grant : '0;

  // Reset in ISSUE must kill the store in that same cycle, so gate the registered enable.
  assign st_en_o = st_en_q && !rst_i;

  // Load data arrives from the LSU during RESP; zero for stores and decode errors.
  assign rsp_rdata_o = (state == RESP && !lat_we && !lat_err) ? ld_data_i : '0;

  // Access sequencer: handshake in IDLE, drive LSU in ISSUE, respond and update lock in RESP.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= only, so every register here sees pre-edge values.
    if (rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      lock_owner  <= '0;
      lock_valid  <= 1'b0;
      lat_we      <= 1'b0;
      lat_err     <= 1'b0;
      st_en_q     <= 1'b0;
      addr_o      <= '0;
      st_data_o   <= '0;
      ld_st_sel_o <= '0;
      rsp_valid_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner       <= grant_idx;
            lat_we      <= sel_we;
            lat_err     <= sel_err;
            addr_o      <= sel_addr;
            st_data_o   <= sel_wdata;
            ld_st_sel_o <= sel_sel;
            st_en_q     <= sel_we && !sel_err;
            if (ARB_MODE == 1) begin
              rr_ptr <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          st_en_q     <= 1'b0;
          rsp_valid_o <= owner_mask;
          rsp_err_o   <= lat_err;
          state       <= RESP;
        end
        RESP: begin
          rsp_valid_o <= '0;
          rsp_err_o   <= 1'b0;
          addr_o      <= '0;
          st_data_o   <= '0;
          ld_st_sel_o <= '0;
          lock_valid  <= req_lock_i[owner];
          lock_owner  <= owner;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
